// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: serialises handshaked words LSB-first into a programmable Mealy pattern detector with match count/position
module seq_det_ctrl #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [MAX_LEN-1:0]          cfg_pat,
    input  logic [$clog2(MAX_LEN):0]    cfg_len,
    input  logic                        cfg_ovl,
    output logic                        cfg_err,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic                        clr_cnt,
    output logic                        busy,
    output logic                        match,
    output logic [$clog2(DATA_W)-1:0]   match_pos,
    output logic [CNT_W-1:0]            match_cnt
);
    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int PW = $clog2(DATA_W);
    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;
    localparam logic [PW-1:0] LAST = PW'(DATA_W - 1);
    localparam logic [LW-1:0] FULL = LW'(MAX_LEN);

    logic                state;
    logic [DATA_W-1:0]   word;
    logic [PW-1:0]       idx;
    logic [MAX_LEN-1:0]  pat, hist, cand, mask;
    logic [LW-1:0]       len, hv;
    logic                ovl, bit_in, hit, cfg_ok, accept;

    assign in_ready = (state == IDLE) && !cfg_we;
    assign busy     = (state == SHIFT);

    // only the low len bits of the candidate take part in the comparison
    always_comb begin
        bit_in = word[idx];
        cand   = {hist[MAX_LEN-2:0], bit_in};
        mask   = ~({MAX_LEN{1'b1}} << len);
        hit    = (state == SHIFT) && (((cand ^ pat) & mask) == '0) && (hv >= len - LW'(1));
        cfg_ok = (state == IDLE) && (cfg_len != '0) && (cfg_len <= FULL);
        accept = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word      <= '0;
            idx       <= '0;
            pat       <= '0;
            len       <= FULL;
            ovl       <= 1'b1;
            hist      <= '0;
            hv        <= '0;
            match     <= 1'b0;
            match_pos <= '0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err   <= cfg_we && !cfg_ok;
            match     <= hit;
            if (hit) match_pos <= idx;
            match_cnt <= clr_cnt ? (hit ? CNT_W'(1) : '0)
                       : (hit && !(&match_cnt)) ? match_cnt + CNT_W'(1) : match_cnt;
            if (cfg_we && cfg_ok) begin
                pat  <= cfg_pat;
                len  <= cfg_len;
                ovl  <= cfg_ovl;
                hist <= '0;
                hv   <= '0;
            end
            if (accept) begin
                state <= SHIFT;
                word  <= in_data;
                idx   <= '0;
            end
            // non-overlapping mode restarts history qualification after every hit
            if (state == SHIFT) begin
                hist <= cand;
                hv   <= (hit && !ovl) ? '0 : (hv == FULL) ? FULL : hv + LW'(1);
                idx  <= idx + PW'(1);
                if (idx == LAST) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: table-driven vectors with a match-position scoreboard plus multi-cycle corner sequences
module tb_seq_det_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, cfg_ovl = 1'b0, in_valid = 1'b0, clr_cnt = 1'b0;
    logic [7:0]  cfg_pat = '0, in_data = '0;
    logic [3:0]  cfg_len = '0;
    logic        cfg_err, in_ready, busy, match;
    logic [2:0]  match_pos;
    logic [15:0] match_cnt;
    logic        sat_cfg_err, sat_in_ready, sat_busy, sat_match;
    logic [2:0]  sat_match_pos;
    logic [1:0]  sat_match_cnt;
    int total = 0, bad = 0;
    int q[$];

    typedef struct {
        logic       do_cfg;
        logic       clr;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       err;
        logic [7:0] data;
        logic [7:0] mask;
        int         cnt;
    } vec_t;
    vec_t vt[11];

    seq_det_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .cfg_err(cfg_err), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clr_cnt(clr_cnt), .busy(busy), .match(match),
        .match_pos(match_pos), .match_cnt(match_cnt)
    );

    seq_det_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .cfg_err(sat_cfg_err), .in_valid(in_valid), .in_data(in_data),
        .in_ready(sat_in_ready), .clr_cnt(clr_cnt), .busy(sat_busy), .match(sat_match),
        .match_pos(sat_match_pos), .match_cnt(sat_match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && match) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_match: pos %0d with no match expected", match_pos);
            end else begin
                int e;
                e = q.pop_front();
                chk("match_pos", match_pos, e);
            end
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_match"}, match, 0);
        chk({tag, "_cnt"}, match_cnt, 0);
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_err"}, cfg_err, 0);
        chk({tag, "_pos"}, match_pos, 0);
        chk({tag, "_sat_busy"}, sat_busy, 0);
        chk({tag, "_sat_match"}, sat_match, 0);
        chk({tag, "_sat_cnt"}, sat_match_cnt, 0);
        chk({tag, "_sat_ready"}, sat_in_ready, 1);
        chk({tag, "_sat_err"}, sat_cfg_err, 0);
        chk({tag, "_sat_pos"}, sat_match_pos, 0);
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic c, input logic e);
        @(negedge clk);
        cfg_we = 1'b1; cfg_pat = p; cfg_len = l; cfg_ovl = o; clr_cnt = c;
        #1 chk("cfg_ready_low", in_ready, 0);
        @(posedge clk);
        #1 cfg_we = 1'b0; clr_cnt = 1'b0;
        chk("cfg_err", cfg_err, e);
        if (c) chk("cfg_clr_cnt", match_cnt, 0);
    endtask

    // mode: 0 plain, 1 config write during SHIFT, 2 clear on a hit cycle, 3 reset at bit 4
    task automatic send(input logic [7:0] d, input logic [7:0] m, input int cnt, input int mode);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (m[i]) q.push_back(i);
        @(negedge clk);
        chk("ready_idle", in_ready, 1);
        in_valid = 1'b1; in_data = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (mode == 1 && n == 2) begin cfg_we = 1'b1; cfg_pat = 8'h00; cfg_len = 4'd1; end
            if (mode == 1 && n == 3) begin chk("busy_cfg_err", cfg_err, 1); cfg_we = 1'b0; end
            if (mode == 1 && n == 4) chk("busy_cfg_err_pulse", cfg_err, 0);
            if (mode == 2 && n == 4) clr_cnt = 1'b1;
            if (mode == 2 && n == 5) begin
                clr_cnt = 1'b0;
                chk("clr_hit_cnt", match_cnt, 1);
                chk("clr_hit_sat", sat_match_cnt, 1);
            end
            if (mode == 3 && n == 5) begin
                rst_n = 1'b0;
                #1 reset_checks("midrst");
                q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        chk("shift_cycles", n, 8);
        @(negedge clk);
        chk("cnt", match_cnt, cnt);
        chk("missed_matches", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b1, 1'b1, 8'h05, 4'd4, 1'b1, 1'b0, 8'hAA, 8'hA8, 3};
        vt[1]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'hAA, 8'hAA, 7};
        vt[2]  = '{1'b1, 1'b1, 8'h05, 4'd4, 1'b0, 1'b0, 8'hAA, 8'h88, 2};
        vt[3]  = '{1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 8'hAA, 8'h88, 4};
        vt[4]  = '{1'b1, 1'b0, 8'h00, 4'd9, 1'b1, 1'b1, 8'hAA, 8'h88, 6};
        vt[5]  = '{1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 8'h5A, 8'h5A, 4};
        vt[6]  = '{1'b1, 1'b1, 8'h00, 4'd1, 1'b0, 1'b0, 8'h5A, 8'hA5, 4};
        vt[7]  = '{1'b1, 1'b1, 8'h0F, 4'd8, 1'b1, 1'b0, 8'hF0, 8'h80, 1};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'hF0, 8'h80, 2};
        vt[9]  = '{1'b1, 1'b1, 8'h06, 4'd3, 1'b1, 1'b0, 8'h36, 8'h48, 2};
        vt[10] = '{1'b1, 1'b1, 8'h02, 4'd2, 1'b0, 1'b0, 8'hAA, 8'h54, 3};
        #1 reset_checks("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (vt[i].do_cfg) cfg(vt[i].pat, vt[i].len, vt[i].ovl, vt[i].clr, vt[i].err);
            send(vt[i].data, vt[i].mask, vt[i].cnt, 0);
        end
        cfg(8'h05, 4'd4, 1'b1, 1'b1, 1'b0);
        send(8'hAA, 8'hA8, 3, 1);
        cfg(8'h01, 4'd1, 1'b1, 1'b1, 1'b0);
        send(8'hFF, 8'hFF, 8, 0);
        chk("sat_cnt", sat_match_cnt, 3);
        send(8'hFF, 8'hFF, 5, 2);
        chk("sat_cnt_after_clr", sat_match_cnt, 3);
        cfg(8'h01, 4'd1, 1'b1, 1'b1, 1'b0);
        send(8'hFF, 8'hFF, 0, 3);
        send(8'h00, 8'h80, 1, 0);
        send(8'h00, 8'hFF, 9, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
